// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: shared definitions for the compare/classify unit.
//   - op encodings (3 bits)
//   - FCLASS result bit indices
//   - canonical quiet NaN
//   - fp_fields_t: decoded operand fields captured in stage 1
package fp_cmp_pkg;

    localparam logic [2:0] OP_FMIN   = 3'b000;
    localparam logic [2:0] OP_FMAX   = 3'b001;
    localparam logic [2:0] OP_FEQ    = 3'b010;
    localparam logic [2:0] OP_FLT    = 3'b011;
    localparam logic [2:0] OP_FLE    = 3'b100;
    localparam logic [2:0] OP_FCLASS = 3'b101;

    localparam int unsigned FC_NEG_INF  = 0;
    localparam int unsigned FC_NEG_NORM = 1;
    localparam int unsigned FC_NEG_SUB  = 2;
    localparam int unsigned FC_NEG_ZERO = 3;
    localparam int unsigned FC_POS_ZERO = 4;
    localparam int unsigned FC_POS_SUB  = 5;
    localparam int unsigned FC_POS_NORM = 6;
    localparam int unsigned FC_POS_INF  = 7;
    localparam int unsigned FC_SNAN     = 8;
    localparam int unsigned FC_QNAN     = 9;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic        exp_zero;
        logic        exp_ones;
        logic        man_zero;
        logic        quiet;     // man[22]
        logic [31:0] raw;
    } fp_fields_t;

endpackage

// File: rtl/fp_field_decode.sv
// fp_field_decode: combinational binary32 field extraction.
// Ports:
//   word    in  32  IEEE-754 single-precision word
//   fields  out     decoded fp_fields_t
module fp_field_decode
    import fp_cmp_pkg::*;
(
    input  logic [31:0] word,
    output fp_fields_t  fields
);

    always_comb begin
        fields.sign     = word[31];
        fields.exp_zero = (word[30:23] == 8'h00);
        fields.exp_ones = (word[30:23] == 8'hFF);
        fields.man_zero = (word[22:0] == 23'd0);
        fields.quiet    = word[22];
        fields.raw      = word;
    end

endmodule

// File: rtl/fp_cmp_class.sv
// fp_cmp_class: two-stage pipelined binary32 FMIN/FMAX/FEQ/FLT/FLE/FCLASS.
// Stage 1 registers decoded operand fields and op; stage 2 registers rd/nv.
// Valid/ready handshake on both sides with full backpressure.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready combinational from out_ready)
//   op[2:0]             operation select (see fp_cmp_pkg)
//   rs1, rs2            operands (rs2 ignored for FCLASS)
//   out_valid/out_ready result handshake
//   rd[31:0], nv        result and invalid-operation flag
// Configuration: define FP_CMP_NV_EN to compute nv; otherwise nv is tied 0.
module fp_cmp_class
    import fp_cmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rd,
    output logic        nv
);

    fp_fields_t dec_a, dec_b;

    fp_field_decode u_dec_a (.word(rs1), .fields(dec_a));
    fp_field_decode u_dec_b (.word(rs2), .fields(dec_b));

    logic        s1_valid_q;
    logic [2:0]  s1_op_q;
    fp_fields_t  s1_a_q, s1_b_q;
    logic        s2_valid_q;
    logic [31:0] rd_q, rd_d;
    logic        nv_q, nv_d;

    logic s2_adv, s1_adv;

    assign s2_adv    = ~s2_valid_q | out_ready;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign in_ready  = ~rst & s1_adv;
    assign out_valid = s2_valid_q;
    assign rd        = rd_q;
    assign nv        = nv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            rd_q       <= '0;
            nv_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q <= op;
                    s1_a_q  <= dec_a;
                    s1_b_q  <= dec_b;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rd_q <= rd_d;
                    nv_q <= nv_d;
                end
            end
        end
    end

    // Stage 2 combinational evaluation
    logic a_nan, b_nan, both_zero, mag_lt, mag_gt;
    logic lt_total, lt_ord, eq_ord;
    logic a_sub, a_norm, a_zero, a_inf;

    assign a_nan     = s1_a_q.exp_ones & ~s1_a_q.man_zero;
    assign b_nan     = s1_b_q.exp_ones & ~s1_b_q.man_zero;
    assign both_zero = s1_a_q.exp_zero & s1_a_q.man_zero & s1_b_q.exp_zero & s1_b_q.man_zero;
    assign mag_lt    = s1_a_q.raw[30:0] < s1_b_q.raw[30:0];
    assign mag_gt    = s1_a_q.raw[30:0] > s1_b_q.raw[30:0];

    // Total order over non-NaN values with -0 < +0; between negatives the
    // larger magnitude is smaller.
    assign lt_total = (s1_a_q.sign != s1_b_q.sign) ? s1_a_q.sign :
                      (s1_a_q.sign ? mag_gt : mag_lt);
    // IEEE comparisons treat the two zeros as equal.
    assign lt_ord   = lt_total & ~both_zero;
    assign eq_ord   = (s1_a_q.raw == s1_b_q.raw) | both_zero;

    assign a_zero = s1_a_q.exp_zero & s1_a_q.man_zero;
    assign a_sub  = s1_a_q.exp_zero & ~s1_a_q.man_zero;
    assign a_inf  = s1_a_q.exp_ones & s1_a_q.man_zero;
    assign a_norm = ~s1_a_q.exp_zero & ~s1_a_q.exp_ones;

    always_comb begin
        rd_d = '0;
        case (s1_op_q)
            OP_FMIN, OP_FMAX: begin
                if (a_nan && b_nan) begin
                    rd_d = CANON_NAN;
                end else if (a_nan) begin
                    rd_d = s1_b_q.raw;
                end else if (b_nan) begin
                    rd_d = s1_a_q.raw;
                end else if (s1_op_q == OP_FMIN) begin
                    rd_d = lt_total ? s1_a_q.raw : s1_b_q.raw;
                end else begin
                    rd_d = lt_total ? s1_b_q.raw : s1_a_q.raw;
                end
            end
            OP_FEQ: rd_d[0] = ~a_nan & ~b_nan & eq_ord;
            OP_FLT: rd_d[0] = ~a_nan & ~b_nan & lt_ord;
            OP_FLE: rd_d[0] = ~a_nan & ~b_nan & (lt_ord | eq_ord);
            OP_FCLASS: begin
                rd_d[FC_NEG_INF]  = s1_a_q.sign & a_inf;
                rd_d[FC_NEG_NORM] = s1_a_q.sign & a_norm;
                rd_d[FC_NEG_SUB]  = s1_a_q.sign & a_sub;
                rd_d[FC_NEG_ZERO] = s1_a_q.sign & a_zero;
                rd_d[FC_POS_ZERO] = ~s1_a_q.sign & a_zero;
                rd_d[FC_POS_SUB]  = ~s1_a_q.sign & a_sub;
                rd_d[FC_POS_NORM] = ~s1_a_q.sign & a_norm;
                rd_d[FC_POS_INF]  = ~s1_a_q.sign & a_inf;
                rd_d[FC_SNAN]     = a_nan & ~s1_a_q.quiet;
                rd_d[FC_QNAN]     = a_nan & s1_a_q.quiet;
            end
            default: rd_d = '0;
        endcase
    end

`ifdef FP_CMP_NV_EN
    logic any_snan;
    assign any_snan = (a_nan & ~s1_a_q.quiet) | (b_nan & ~s1_b_q.quiet);

    always_comb begin
        nv_d = 1'b0;
        case (s1_op_q)
            OP_FMIN, OP_FMAX, OP_FEQ: nv_d = any_snan;
            OP_FLT, OP_FLE:           nv_d = a_nan | b_nan;
            default:                  nv_d = 1'b0;
        endcase
    end
`else
    assign nv_d = 1'b0;

    // Quiet bit of rs2 only matters for the invalid flag.
    logic unused_quiet;
    assign unused_quiet = s1_b_q.quiet;
`endif

endmodule

// File: tb/tb_fp_cmp_class.sv
// tb_fp_cmp_class: table-driven check of fp_cmp_class plus hand-written
// backpressure and reset sequences.
module tb_fp_cmp_class;

    localparam logic [2:0] FMIN = 3'd0, FMAX = 3'd1, FEQ = 3'd2, FLT = 3'd3,
                           FLE = 3'd4, FCLS = 3'd5, RSV = 3'd6;
`ifdef FP_CMP_NV_EN
    localparam bit NvEn = 1'b1;
`else
    localparam bit NvEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        nv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_cmp_class dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .nv        (nv)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic        nv;   // value with the invalid flag enabled
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{FMIN, 32'h40866666, 32'h404CCCCC, 32'h404CCCCC, 1'b0});
        vecs.push_back('{FMAX, 32'h40866666, 32'h404CCCCC, 32'h40866666, 1'b0});
        vecs.push_back('{FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{FMAX, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0});
        vecs.push_back('{FLE,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{FLT,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{FEQ,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{FLT,  32'h7FA00000, 32'h3F800000, 32'h00000000, 1'b1});
        vecs.push_back('{FLE,  32'h3F800000, 32'h7FC00000, 32'h00000000, 1'b1});
        vecs.push_back('{FEQ,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0});
        vecs.push_back('{FEQ,  32'h3F800000, 32'h7FA00000, 32'h00000000, 1'b1});
        vecs.push_back('{FEQ,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0});
        vecs.push_back('{FMAX, 32'h7FC00000, 32'hBF000000, 32'hBF000000, 1'b0});
        vecs.push_back('{FMIN, 32'h3F800000, 32'h7FA00000, 32'h3F800000, 1'b1});
        vecs.push_back('{FMIN, 32'h7FA00000, 32'h7FC00000, 32'h7FC00000, 1'b1});
        vecs.push_back('{FMAX, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0});
        vecs.push_back('{FMIN, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0});
        vecs.push_back('{FMAX, 32'hC0000000, 32'hBF800000, 32'hBF800000, 1'b0});
        vecs.push_back('{FLT,  32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0});
        vecs.push_back('{FLE,  32'h40000000, 32'h3F800000, 32'h00000000, 1'b0});
        vecs.push_back('{FLT,  32'hBF800000, 32'h3F800000, 32'h00000001, 1'b0});
        vecs.push_back('{FCLS, 32'hBF000000, 32'h00000000, 32'h00000002, 1'b0});
        vecs.push_back('{FCLS, 32'h00000001, 32'h7FA00000, 32'h00000020, 1'b0});
        vecs.push_back('{FCLS, 32'hFF800000, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{FCLS, 32'h7FA00000, 32'h00000000, 32'h00000100, 1'b0});
        vecs.push_back('{FCLS, 32'h7FC00000, 32'h00000000, 32'h00000200, 1'b0});
        vecs.push_back('{FCLS, 32'h00000000, 32'h00000000, 32'h00000010, 1'b0});
        vecs.push_back('{FCLS, 32'h80000000, 32'h00000000, 32'h00000008, 1'b0});
        vecs.push_back('{FCLS, 32'h80000001, 32'h00000000, 32'h00000004, 1'b0});
        vecs.push_back('{FCLS, 32'h3F800000, 32'h00000000, 32'h00000040, 1'b0});
        vecs.push_back('{FCLS, 32'h7F800000, 32'h00000000, 32'h00000080, 1'b0});
        vecs.push_back('{RSV,  32'h3F800000, 32'h40000000, 32'h00000000, 1'b0});

        rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset rd", rd, 32'd0);
        chk("reset nv", {31'd0, nv}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Table: present in cycle 0, result must be visible in cycle 2.
        foreach (vecs[i]) begin
            in_valid = 1'b1; op = vecs[i].op; rs1 = vecs[i].a; rs2 = vecs[i].b;
            #1;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d early out_valid", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d rd", i), rd, vecs[i].rd);
            chk($sformatf("v%0d nv", i), {31'd0, nv}, {31'd0, vecs[i].nv & NvEn});
            tick();
        end

        // Backpressure: stall output for 5 cycles, three requests queued.
        begin
            logic [2:0]  bop [3];
            logic [31:0] ba  [3];
            logic [31:0] bb  [3];
            logic [31:0] bexp[3];
            int idx = 0, nout = 0, first = -1, last = -1;
            bop[0] = FLT;  ba[0] = 32'hC0CCCCCC; bb[0] = 32'h40CCCCCC; bexp[0] = 32'h1;
            bop[1] = FMAX; ba[1] = 32'h3F800000; bb[1] = 32'h40000000; bexp[1] = 32'h40000000;
            bop[2] = FCLS; ba[2] = 32'h3F800000; bb[2] = 32'h0;        bexp[2] = 32'h40;
            for (int c = 0; c < 20 && nout < 3; c++) begin
                in_valid  = (idx < 3);
                op        = bop[idx < 3 ? idx : 2];
                rs1       = ba[idx < 3 ? idx : 2];
                rs2       = bb[idx < 3 ? idx : 2];
                out_ready = (c >= 5);
                #1;
                if (c < 5 && out_valid) begin
                    chk($sformatf("stall rd c%0d", c), rd, 32'h1);
                    chk($sformatf("stall nv c%0d", c), {31'd0, nv}, 32'd0);
                end
                if (c == 4) begin
                    chk("stall accepted count", idx, 2);
                    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("drain rd %0d", nout), rd, bexp[nout]);
                    if (first < 0) first = c;
                    last = c;
                    nout++;
                end
                if (in_valid && in_ready) idx++;
                tick();
            end
            in_valid = 1'b0;
            chk("drain count", nout, 3);
            chk("drain first cycle", first, 5);
            chk("drain last cycle", last, 7);
        end

        // Reset with both stages full and output stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; op = FMAX; rs1 = 32'h3F800000; rs2 = 32'h40000000;
        tick();
        op = FLT; rs1 = 32'hC0CCCCCC; rs2 = 32'h40CCCCCC;
        tick();
        in_valid = 1'b0;
        #1;
        chk("full out_valid", {31'd0, out_valid}, 32'd1);
        chk("full in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("post-rst rd", rd, 32'd0);
        chk("post-rst nv", {31'd0, nv}, 32'd0);
        chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        begin
            int stale = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (out_valid) stale++;
            end
            chk("no stale result", stale, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
